// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// FETCH_COUNT_EN adds the num_fetch counter to instr_fetch_unit.
package fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DFLT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, memory request handshake and IF/ID output hold.
// Define FETCH_COUNT_EN to expose the num_fetch accepted-instruction counter.
module instr_fetch_unit #(
  parameter int WORD_W = fetch_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = fetch_pkg::RESET_PC_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              i_readM,
  output logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data,
  input  logic              inputReady,
  input  logic              IFID_WriteEn,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] IF_PC4,
  output logic [WORD_W-1:0] IF_instruction,
  output logic              IF_valid,
  output logic              IF_flush
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       num_fetch
`endif
);

  import fetch_pkg::*;

  localparam logic [WORD_W-1:0] ONE = WORD_W'(1);

  fetch_state_e state_q, state_d;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pc4_q, pc4_d;
  logic [WORD_W-1:0] ins_q, ins_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic              readm_q, readm_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    ins_d   = ins_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    readm_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (branch_taken) begin
          pc_d    = branch_target;
          flush_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          flush_d = 1'b1;
          // an issued access cannot be cancelled; wait it out
          state_d = inputReady ? ST_REQ : ST_DRAIN;
        end else if (inputReady) begin
          ins_d   = i_data;
          pc4_d   = pc_q + ONE;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          flush_d = 1'b1;
          state_d = ST_REQ;
        end else if (IFID_WriteEn) begin
          pc_d    = pc_q + ONE;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          flush_d = 1'b1;
        end
        if (inputReady) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // DRAIN keeps the old address on the bus until the stale reply lands
    readm_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    if (state_d == ST_REQ) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      ins_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      readm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      ins_q   <= ins_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      readm_q <= readm_d;
    end
  end

  assign i_readM        = readm_q;
  assign i_address      = addr_q;
  assign IF_PC4         = pc4_q;
  assign IF_instruction = ins_q;
  assign IF_valid       = valid_q;
  assign IF_flush       = flush_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q;
  logic        accept;

  assign accept = (state_q == ST_HOLD) && IFID_WriteEn && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign num_fetch = cnt_q;
`endif

endmodule
